// File: rtl/dcache_pkg.sv
// Shared configuration, field slices, FSM encoding and helpers for the
// direct-mapped write-back data cache.
package dcache_pkg;

  localparam int ADDR_W     = 8;
  localparam int INDEX_W    = 3;
  localparam int OFFSET_W   = 2;
  localparam int TAG_W      = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NUM_BLOCKS = 1 << INDEX_W;
  localparam int BLOCK_W    = 32;

  localparam int TAG_MSB    = ADDR_W - 1;
  localparam int INDEX_MSB  = INDEX_W + OFFSET_W - 1;
  localparam int OFFSET_MSB = OFFSET_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FETCH     = 2'd2,
    ST_UPDATE    = 2'd3
  } state_e;

  function automatic logic [7:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                            input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: data/tag arrays plus valid/dirty bits, combinational read,
// synchronous byte and block write ports, async clear of valid/dirty.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [INDEX_W-1:0]  rd_index_i,
  output logic [BLOCK_W-1:0]  rd_data_o,
  output logic [TAG_W-1:0]    rd_tag_o,
  output logic                rd_valid_o,
  output logic                rd_dirty_o,
  input  logic                byte_we_i,
  input  logic [INDEX_W-1:0]  byte_index_i,
  input  logic [OFFSET_W-1:0] byte_offset_i,
  input  logic [7:0]          byte_data_i,
  input  logic                blk_we_i,
  input  logic [INDEX_W-1:0]  blk_index_i,
  input  logic [TAG_W-1:0]    blk_tag_i,
  input  logic [BLOCK_W-1:0]  blk_data_i
);

  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [NUM_BLOCKS-1:0] dirty_q;

  // Line status bits; a block fill leaves the line clean, a byte store dirties it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (blk_we_i) begin
      valid_q[blk_index_i] <= 1'b1;
      dirty_q[blk_index_i] <= 1'b0;
    end else if (byte_we_i) begin
      dirty_q[byte_index_i] <= 1'b1;
    end
  end

  // Payload storage needs no reset: it is only observed through a valid line.
  always_ff @(posedge clk_i) begin
    if (blk_we_i) begin
      data_q[blk_index_i] <= blk_data_i;
      tag_q[blk_index_i]  <= blk_tag_i;
    end else if (byte_we_i) begin
      data_q[byte_index_i][{byte_offset_i, 3'b000} +: 8] <= byte_data_i;
    end
  end

  assign rd_data_o  = data_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_dirty_o = dirty_q[rd_index_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU
// byte port and a 32-bit-block data memory.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  state_e               state_q, state_d;
  logic [BLOCK_W-1:0]   fill_q, fill_d;
  logic [TAG_W-1:0]     addr_tag;
  logic [INDEX_W-1:0]   addr_index;
  logic [OFFSET_W-1:0]  addr_offset;
  logic [BLOCK_W-1:0]   line_data;
  logic [TAG_W-1:0]     line_tag;
  logic                 line_valid;
  logic                 line_dirty;
  logic                 req;
  logic                 hit;
  logic                 byte_we;
  logic                 blk_we;

  assign addr_tag    = ADDRESS[TAG_MSB:INDEX_MSB+1];
  assign addr_index  = ADDRESS[INDEX_MSB:OFFSET_MSB+1];
  assign addr_offset = ADDRESS[OFFSET_MSB:0];

  assign req     = read | write;
  assign hit     = line_valid && (line_tag == addr_tag);
  assign byte_we = (state_q == ST_IDLE) && hit && write;

  // BUSYWAIT is also gated by RESET so an abandoned miss releases the CPU at once.
  assign BUSYWAIT = RESET && req && !((state_q == ST_IDLE) && hit);
  assign READDATA = line_valid ? block_byte(line_data, addr_offset) : 8'h00;

  dcache_array u_array (
    .clk_i         (CLK),
    .rst_ni        (RESET),
    .rd_index_i    (addr_index),
    .rd_data_o     (line_data),
    .rd_tag_o      (line_tag),
    .rd_valid_o    (line_valid),
    .rd_dirty_o    (line_dirty),
    .byte_we_i     (byte_we),
    .byte_index_i  (addr_index),
    .byte_offset_i (addr_offset),
    .byte_data_i   (WRITEDATA),
    .blk_we_i      (blk_we),
    .blk_index_i   (addr_index),
    .blk_tag_i     (addr_tag),
    .blk_data_i    (fill_q)
  );

  // FSM state and captured fill block.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Next-state and memory-side request decode.
  always_comb begin
    state_d       = state_q;
    fill_d        = fill_q;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = {addr_tag, addr_index};
    mem_writedata = line_data;
    blk_we        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req && !hit) begin
          state_d = (line_valid && line_dirty) ? ST_WRITEBACK : ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        mem_write   = 1'b1;
        mem_address = {line_tag, addr_index};
        if (!mem_busywait) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_FETCH: begin
        mem_read = 1'b1;
        if (!mem_busywait) begin
          fill_d  = mem_readdata;
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_UPDATE: begin
        blk_we  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: directed CPU operations push expected
// CPU and memory transactions; independent monitors pop and compare them.
module tb_dcache_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        read;
  logic        write;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  typedef struct {
    logic       is_write;
    logic [7:0] rdata;
    int         stall;
  } cpu_exp_t;

  typedef struct {
    logic        is_write;
    logic [5:0]  addr;
    logic [31:0] wdata;
  } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] mem [64];
  logic        init_done = 1'b0;
  int          mem_delay = 0;
  int          cnt = 0;

  dcache_controller dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .read          (read),
    .write         (write),
    .ADDRESS       (ADDRESS),
    .WRITEDATA     (WRITEDATA),
    .READDATA      (READDATA),
    .BUSYWAIT      (BUSYWAIT),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 CLK = ~CLK;

  // Block memory: busy for mem_delay cycles per request, garbage data while busy.
  always @(posedge CLK) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= {4{8'(i)}};
      mem[9]    <= 32'h44332211;
      mem[6'h29] <= 32'h88776655;
      init_done <= 1'b1;
    end else if (mem_write && cnt == 0) begin
      mem[mem_address] <= mem_writedata;
    end
    if (!(mem_read || mem_write)) cnt <= mem_delay;
    else if (cnt != 0) cnt <= cnt - 1;
  end

  assign mem_busywait = (mem_read || mem_write) && (cnt != 0);
  assign mem_readdata = (cnt != 0) ? 32'hDEADBEEF : mem[mem_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic w, input logic [5:0] a, input logic [31:0] d);
    mem_exp_t e;
    e.is_write = w;
    e.addr     = a;
    e.wdata    = d;
    mem_q.push_back(e);
  endtask

  task automatic cpu_op(input logic w, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input int exp_stall);
    cpu_exp_t e;
    logic done;
    e.is_write = w;
    e.rdata    = exp_rd;
    e.stall    = exp_stall;
    cpu_q.push_back(e);
    read      = !w;
    write     = w;
    ADDRESS   = a;
    WRITEDATA = wd;
    done      = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (!BUSYWAIT) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cpu_timeout: addr 0x%0h still stalled, required completion", a);
    end
    @(posedge CLK);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  // CPU-side monitor: counts stall cycles and scores each completed request.
  initial begin : cpu_mon
    int stall_cnt;
    cpu_exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        stall_cnt = 0;
      end else if (read || write) begin
        if (BUSYWAIT) begin
          stall_cnt++;
        end else if (cpu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_unexpected: completion at addr 0x%0h, required none", ADDRESS);
          stall_cnt = 0;
        end else begin
          e = cpu_q.pop_front();
          check("cpu_stall", 32'(stall_cnt), 32'(e.stall));
          if (!e.is_write) check("cpu_rdata", 32'(READDATA), 32'(e.rdata));
          stall_cnt = 0;
        end
      end else begin
        check("idle_busywait", 32'(BUSYWAIT), 32'd0);
      end
    end
  end

  // Memory-side monitor: request stability while busy, transaction scoring at completion.
  initial begin : mem_mon
    logic       in_busy;
    logic [5:0] prev_addr;
    mem_exp_t   e;
    in_busy   = 1'b0;
    prev_addr = 6'd0;
    forever begin
      @(negedge CLK);
      if (RESET && (mem_read || mem_write)) begin
        check("mem_exclusive", 32'(mem_read & mem_write), 32'd0);
        if (in_busy) check("mem_addr_stable", 32'(mem_address), 32'(prev_addr));
        if (mem_busywait) begin
          in_busy   = 1'b1;
          prev_addr = mem_address;
        end else begin
          in_busy = 1'b0;
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected: request at 0x%0h, required none", mem_address);
          end else begin
            e = mem_q.pop_front();
            check("mem_kind", 32'(mem_write), 32'(e.is_write));
            check("mem_addr", 32'(mem_address), 32'(e.addr));
            if (e.is_write) check("mem_wdata", mem_writedata, e.wdata);
          end
        end
      end else begin
        in_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic seen;
    RESET = 1'b0; read = 1'b0; write = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    repeat (2) @(negedge CLK);
    check("rst_busywait", 32'(BUSYWAIT), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_readdata", 32'(READDATA), 32'd0);
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1;

    // Cold read miss, write hit, read hit.
    exp_mem(1'b0, 6'h09, 32'h0);
    cpu_op(1'b0, 8'h25, 8'h00, 8'h22, 3);
    cpu_op(1'b1, 8'h24, 8'hAB, 8'h00, 0);
    cpu_op(1'b0, 8'h24, 8'h00, 8'hAB, 0);

    // Dirty eviction on index 1.
    exp_mem(1'b1, 6'h09, 32'h443322AB);
    exp_mem(1'b0, 6'h29, 32'h0);
    cpu_op(1'b0, 8'hA5, 8'h00, 8'h66, 4);

    // Tag 7 / index 7 write-allocate, then hits on the same line.
    exp_mem(1'b0, 6'h3F, 32'h0);
    cpu_op(1'b1, 8'hFF, 8'hFF, 8'h00, 3);
    cpu_op(1'b0, 8'hFC, 8'h00, 8'h3F, 0);
    cpu_op(1'b0, 8'hFF, 8'h00, 8'hFF, 0);

    // Slow memory: five busy cycles in FETCH.
    mem_delay = 5;
    exp_mem(1'b0, 6'h02, 32'h0);
    cpu_op(1'b0, 8'h0A, 8'h00, 8'h02, 8);
    mem_delay = 0;

    // Dirty write miss and dirty read miss ping-ponging index 7.
    exp_mem(1'b1, 6'h3F, 32'hFF3F3F3F);
    exp_mem(1'b0, 6'h07, 32'h0);
    cpu_op(1'b1, 8'h1F, 8'h11, 8'h00, 4);
    exp_mem(1'b1, 6'h07, 32'h11070707);
    exp_mem(1'b0, 6'h3F, 32'h0);
    cpu_op(1'b0, 8'hFF, 8'h00, 8'hFF, 4);

    // Reset mid-run invalidates everything.
    RESET = 1'b0;
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1;
    exp_mem(1'b0, 6'h09, 32'h0);
    cpu_op(1'b0, 8'h25, 8'h00, 8'h22, 3);

    // Reset while FETCH is waiting on a slow memory.
    mem_delay = 20;
    read = 1'b1; ADDRESS = 8'h45;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge CLK);
      if (mem_read) seen = 1'b1;
    end
    check("midfetch_mem_read", 32'(mem_read), 32'd1);
    #2 RESET = 1'b0;
    #1;
    check("midfetch_rst_mem_read", 32'(mem_read), 32'd0);
    check("midfetch_rst_busywait", 32'(BUSYWAIT), 32'd0);
    read = 1'b0;
    @(posedge CLK); #1 mem_delay = 0;
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK); #1;
    exp_mem(1'b0, 6'h09, 32'h0);
    cpu_op(1'b0, 8'h25, 8'h00, 8'h22, 3);
    cpu_op(1'b0, 8'h24, 8'h00, 8'hAB, 0);

    repeat (3) @(posedge CLK);
    #1;
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU's data-memory port and the 32-bit-block main data memory.
- CPU side uses the existing 8-bit handshake: read, write, ADDRESS, WRITEDATA, READDATA and BUSYWAIT.
- Memory side issues whole-block reads and writes and waits on mem_busywait.
- Sits directly downstream of the cpu; the testbench top wires cpu ↔ dcache_controller ↔ data memory.

Parameters:
- INDEX_W, 3: index bits; NUM_BLOCKS = 2^INDEX_W (8).
- OFFSET_W, 2: byte-offset bits. Fixed at 2, so a block is 4 bytes (32 bits).
- TAG_W, 8-INDEX_W-OFFSET_W (3): derived; not overridable.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset (RESET=0 resets).
- read  in  1  CPU load request.
- write  in  1  CPU store request.
- ADDRESS  in  8  byte address = {tag, index, offset}.
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data.
- BUSYWAIT  out  1  stall to the CPU.
- mem_read  out  1  block fetch request.
- mem_write  out  1  block writeback request.
- mem_address  out  6  block address = {tag, index}.
- mem_writedata  out  32  evicted block; byte0 in bits [7:0].
- mem_readdata  in  32  fetched block; byte0 in bits [7:0].
- mem_busywait  in  1  memory busy. A request completes at the first rising edge where it is sampled 0 while that request is asserted.

Behaviour:
- Storage: per line, data[32], tag[TAG_W], valid, dirty.
- Reset (RESET=0, asynchronous):
  - all valid and dirty bits cleared; data and tag contents don't-care;
  - FSM forced to IDLE;
  - mem_read=0, mem_write=0, BUSYWAIT=0, READDATA=0.
  - An in-flight memory transaction is abandoned immediately; the memory must tolerate request deassertion.
- Hit: hit = valid[index] && tag[index]==ADDRESS tag. It is combinational from ADDRESS and stored state.
- Outputs:
  - READDATA = the byte of data[index] selected by offset, combinational.
  - BUSYWAIT = (read|write) && !(state==IDLE && hit).
  - No request means BUSYWAIT=0.
- Read hit: zero stall. BUSYWAIT stays 0 and data is valid in the same cycle. No state change.
- Write hit: BUSYWAIT=0. At the next rising edge, the addressed byte is written and dirty[index]=1.
- Request arbitration: read and write together is illegal; the cache treats it as a write. The request must stay stable while BUSYWAIT=1.
- FSM states:
  - IDLE: on miss with a request, go to WRITEBACK if valid&&dirty, else FETCH.
  - WRITEBACK: mem_write=1, mem_address={stored tag, index}, mem_writedata=data[index]. When mem_busywait=0 at an edge, go to FETCH.
  - FETCH: mem_read=1, mem_address={ADDRESS tag, index}. When mem_busywait=0 at an edge, capture mem_readdata and go to UPDATE.
  - UPDATE: at the edge, write the captured block, tag, valid=1, dirty=0, then go to IDLE.
- After a miss: IDLE re-evaluates the request, which now hits, and completes as a normal hit (write hit sets dirty).
- Memory request lines: mem_read and mem_write are never both 1. Both are 0 in IDLE and UPDATE. mem_address, mem_writedata and mem_readdata are don't-care when no request is active.
- Miss latency with a 1-cycle memory: clean miss keeps BUSYWAIT high for 3 cycles (IDLE-miss, FETCH, UPDATE). Dirty miss takes 4 cycles.
- Wrap/boundary cases:
  - index 7 and tag 7 are handled like any other values;
  - a writeback that targets the same index as the fetch is normal;
  - ADDRESS change in IDLE while BUSYWAIT=0 is a new request.

Decomposition:
- Shared package dcache_pkg:
  - FSM state encoding: IDLE=0, WRITEBACK=1, FETCH=2, UPDATE=3;
  - field-slice constants (TAG_MSB, INDEX_MSB, OFFSET_MSB);
  - BLOCK_W=32.
- One sub-module is natural: dcache_array. It holds the data, tag, valid and dirty storage, provides the combinational read, has synchronous byte/block write ports and an async clear.
- The FSM and hit logic stay in dcache_controller.

Test Plan:
- Reset: RESET low mid-run → every read reports miss. BUSYWAIT=1 on first read of 0x25, with mem_read=1 and mem_address=0x09.
- Cold read miss: read 0x25 with memory block 0x44332211 at block 0x09 → FETCH, then UPDATE, then READDATA=0x22. BUSYWAIT falls after exactly 3 cycles with a 1-cycle memory.
- Write hit then read hit: write 0xAB to 0x24 → no stall, dirty[1]=1. Read 0x24 → READDATA=0xAB with BUSYWAIT=0 the same cycle.
- Dirty eviction: read 0xA5 (tag 5, index 1) →
  - mem_write=1, mem_address=0x09, mem_writedata=0x443322AB;
  - then mem_read at mem_address=0x29;
  - BUSYWAIT high for 4 cycles.
- Slow memory: mem_busywait held 1 for 5 cycles during FETCH → mem_read and mem_address stay stable and BUSYWAIT stays 1. The block is captured only at the edge where mem_busywait=0.
- Reset mid-FETCH: RESET=0 while mem_read=1 → mem_read=0 and BUSYWAIT=0 immediately. After release, the line is invalid and the FSM is in IDLE.
